// File: rtl/cpu_param_pkg.sv
// Shared encodings for cpu_param: opcodes, shift codes, FSM states and
// instruction field positions, plus the instruction classifier.
package cpu_param_pkg;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] SH_PASS = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam int RN_LSB = 8;
    localparam int RD_LSB = 5;
    localparam int RM_LSB = 0;
    localparam int SH_LSB = 3;

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG, S_WRITE_IMM
    } state_t;

    typedef enum logic [2:0] {
        K_NOP, K_MOV_IMM, K_MOV_REG, K_ADD, K_CMP, K_AND, K_MVN
    } kind_t;

    // Anything not explicitly listed falls through to NOP.
    function automatic kind_t decode(input logic [15:0] ir);
        kind_t k;
        k = K_NOP;
        if (ir[15:13] == OPC_MOV) begin
            if (ir[12:11] == OP_MOV_IMM)      k = K_MOV_IMM;
            else if (ir[12:11] == OP_MOV_REG) k = K_MOV_REG;
        end else if (ir[15:13] == OPC_ALU) begin
            case (ir[12:11])
                OP_ADD:  k = K_ADD;
                OP_CMP:  k = K_CMP;
                OP_AND:  k = K_AND;
                default: k = K_MVN;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/cpu_param_regfile.sv
// 8 x DW register file: one synchronous write port, two combinational
// read ports, cleared by the asynchronous active-low reset.
module cpu_param_regfile #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [2:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic [2:0]    raddr_a,
    input  logic [2:0]    raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] regs [8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/cpu_param.sv
// Parametrised multi-cycle CPU with s/load/w start handshake.
// Optional carry flag output C when CPU_PARAM_CARRY_FLAG_EN is defined.
//
// state       | meaning
// S_WAIT      | idle, w=1, IR loadable, waiting for s
// S_DECODE    | classify IR, clear A for single-operand ops
// S_GET_A     | latch Rn into A
// S_GET_B     | latch Rm into B
// S_EXEC      | ALU: update out (or flags for CMP)
// S_WRITE_REG | write out to Rd
// S_WRITE_IMM | write ext(imm8) to Rn
module cpu_param
    import cpu_param_pkg::*;
#(
    parameter int DW     = 16,
    parameter bit IMM_SX = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic          load,
    input  logic [15:0]   in,
    output logic [DW-1:0] out,
    output logic          N,
    output logic          V,
    output logic          Z,
    output logic          w
`ifdef CPU_PARAM_CARRY_FLAG_EN
    ,
    output logic          C
`endif
);

    state_t        state;
    kind_t         kind;
    logic [15:0]   ir;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] sh_b;
    logic [DW-1:0] sum;
    logic [DW-1:0] diff;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] imm_ext;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;
    logic          rf_we;
    logic [2:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;

    assign kind    = decode(ir);
    assign imm_ext = IMM_SX ? DW'($signed(ir[7:0])) : DW'(ir[7:0]);

    always_comb begin
        sh_b = b;
        case (ir[SH_LSB +: 2])
            SH_LSL:  sh_b = {b[DW-2:0], 1'b0};
            SH_LSR:  sh_b = {1'b0, b[DW-1:1]};
            SH_ASR:  sh_b = {b[DW-1], b[DW-1:1]};
            default: sh_b = b;
        endcase
    end

    assign sum  = a + sh_b;
    assign diff = a - sh_b;

`ifdef CPU_PARAM_CARRY_FLAG_EN
    logic [DW:0] add_full;
    logic [DW:0] sub_full;
    assign add_full = {1'b0, a} + {1'b0, sh_b};
    assign sub_full = {1'b0, a} + {1'b0, ~sh_b} + (DW+1)'(1);
`endif

    always_comb begin
        alu_res = sum;
        case (kind)
            K_AND:     alu_res = a & sh_b;
            K_MVN:     alu_res = ~sh_b;
            K_MOV_REG: alu_res = sh_b;
            default:   alu_res = sum;
        endcase
    end

    // Write-back always comes from the registered result, so a dest==source
    // op has already consumed the old operand values by the time it lands.
    assign rf_we    = (state == S_WRITE_REG) || (state == S_WRITE_IMM);
    assign rf_waddr = (state == S_WRITE_IMM) ? ir[RN_LSB +: 3] : ir[RD_LSB +: 3];
    assign rf_wdata = (state == S_WRITE_IMM) ? imm_ext : out;

    cpu_param_regfile #(.DW(DW)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (ir[RN_LSB +: 3]),
        .raddr_b (ir[RM_LSB +: 3]),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_WAIT;
            w     <= 1'b1;
            ir    <= '0;
            a     <= '0;
            b     <= '0;
            out   <= '0;
            N     <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b0;
`ifdef CPU_PARAM_CARRY_FLAG_EN
            C     <= 1'b0;
`endif
        end else begin
            case (state)
                S_WAIT: begin
                    if (load) ir <= in;
                    if (s) begin
                        state <= S_DECODE;
                        w     <= 1'b0;
                    end
                end
                S_DECODE: begin
                    case (kind)
                        K_MOV_IMM: state <= S_WRITE_IMM;
                        K_MOV_REG, K_MVN: begin
                            a     <= '0;
                            state <= S_GET_B;
                        end
                        K_ADD, K_CMP, K_AND: state <= S_GET_A;
                        default: begin
                            state <= S_WAIT;
                            w     <= 1'b1;
                        end
                    endcase
                end
                S_GET_A: begin
                    a     <= rdata_a;
                    state <= S_GET_B;
                end
                S_GET_B: begin
                    b     <= rdata_b;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (kind == K_CMP) begin
                        N     <= diff[DW-1];
                        Z     <= (diff == '0);
                        V     <= (a[DW-1] != sh_b[DW-1]) && (diff[DW-1] != a[DW-1]);
`ifdef CPU_PARAM_CARRY_FLAG_EN
                        C     <= sub_full[DW];
`endif
                        state <= S_WAIT;
                        w     <= 1'b1;
                    end else begin
                        out   <= alu_res;
`ifdef CPU_PARAM_CARRY_FLAG_EN
                        if (kind == K_ADD) C <= add_full[DW];
`endif
                        state <= S_WRITE_REG;
                    end
                end
                default: begin
                    state <= S_WAIT;
                    w     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_param.md
Name: cpu_param

Overview:
- Parametrised successor to the lab multi-cycle CPU. Same 16-bit instruction set and `s`/`load`/`w` start handshake.
- Datapath width is configurable. Adds an ASR shift mode, a defined undefined-opcode policy, regfile reset, and a short path for MOV-immediate.
- Sits between the instruction source (switches/bench) and the datapath/regfile, as the lab CPU did.

Parameters:
- DW, 16, datapath/register width in bits; legal range 8..64.
- IMM_SX, 1, 1 = sign-extend imm8 to DW; 0 = zero-extend.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low (asserted when 0).
- s  in  1  start; sampled only in WAIT.
- load  in  1  instruction-register write enable; honoured only while w=1.
- in  in  16  instruction word.
- out  out  DW  registered ALU result (C register).
- N  out  1  negative flag.
- V  out  1  signed-overflow flag.
- Z  out  1  zero flag.
- w  out  1  high in WAIT (ready for s).

Behaviour:
- Encoding:
  - [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm, [7:0] imm8.
  - 110/10 MOV Rn <= ext(imm8); 110/00 MOV Rd <= sh(Rm).
  - 101/00 ADD Rd <= Rn+sh(Rm); 101/01 CMP flags <= Rn-sh(Rm).
  - 101/10 AND Rd <= Rn&sh(Rm); 101/11 MVN Rd <= ~sh(Rm).
  - All other opcode/op combinations are NOP.
- Shifter (sh): 00 pass; 01 LSL1 (LSB=0); 10 LSR1 (MSB=0); 11 ASR1 (MSB copied).
- Arithmetic: all ALU ops are DW bits wide; the carry-out is discarded. V = (a[DW-1]!=b[DW-1]) & (res[DW-1]!=a[DW-1]) for subtraction. Z=1 when res==0; N=res[DW-1].
- FSM states: WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_REG, WRITE_IMM.
  - WAIT --s--> DECODE.
  - DECODE: MOV-imm -> WRITE_IMM; MOV-reg/MVN -> GET_B; ADD/CMP/AND -> GET_A; NOP -> WAIT.
  - GET_A -> GET_B -> EXEC.
  - EXEC -> WRITE_REG, except CMP: EXEC -> WAIT.
  - WRITE_REG and WRITE_IMM -> WAIT.
- Latency, counted from the edge sampling s to the edge re-entering WAIT:
  - MOV-imm 2 cycles; NOP 1 cycle.
  - MOV-reg/MVN 4 cycles; ADD/AND 5 cycles; CMP 4 cycles.
- Register updates:
  - `out` updates in EXEC only, for non-CMP ops; it holds otherwise.
  - N/V/Z update in EXEC only, for CMP; ADD/AND/MVN/MOV do not touch flags.
  - MOV-reg/MVN use A=0 (Rn not read).
- Handshake:
  - w=1 exactly in WAIT.
  - s while not in WAIT is ignored.
  - load while w=0 is ignored (IR holds).
  - load and s on the same WAIT edge: IR captures `in`, and DECODE executes the newly loaded word.
- Reset (async assert, any state, mid-operation included):
  - state=WAIT, w=1, IR=0, out=0, N=V=Z=0, R0..R7=0.
  - An aborted instruction makes no register write.
- Dest==source (e.g. ADD R1,R1,R1) reads the old values; the write lands in WRITE_REG.

Optional Feature:
- Macro: CPU_PARAM_CARRY_FLAG_EN.
- Defined: adds output port C (1 bit, reset 0).
  - C is loaded in EXEC for CMP with the carry-out of Rn + ~sh(Rm) + 1 (1 = no borrow).
  - ADD also loads C with its carry-out.
- Undefined: no C port, no carry logic; ADD never touches flags.

Decomposition:
- Package cpu_param_pkg holds:
  - opcode/op localparams;
  - shift codes;
  - state encoding (enum, 3 bits);
  - field-slice constants (RN_LSB=8, RD_LSB=5, RM_LSB=0, SH_LSB=3).
- One sub-module, cpu_param_regfile: 8 x DW, one write port, two combinational read ports, async active-low clear.
- ALU and shifter stay inline.

Test Plan:
- DW=16: MOV R0,#0x69 with load+s on the same edge -> R0=0x0069, w high 2 cycles later. Then MOV R0,#0xCA -> R0=0xFFCA. With IMM_SX=0, same word -> R0=0x00CA.
- R2=8: MOV R1,R2 LSR -> R1=4; ADD R7,R2,R1 LSL -> R7=16, out=16; CMP R2,R7 LSR -> Z=1, N=0, V=0, flags unchanged by the preceding ADD.
- R4=0x7FFF, R5=0xFFF7: CMP R5,R4 -> N=0, V=1, Z=0. R5=0x8000, CMP R5,R4 -> N=0, V=1, Z=0.
- R0=0x8000: MOV R1,R0 ASR -> 0xC000; LSR -> 0x4000. Undefined opcode 111 -> w returns high after 1 cycle, all registers unchanged.
- Assert reset during GET_B of ADD R1,... -> w=1 immediately, out=0, R1=0, flags=0. s and load pulsed while w=0 -> ignored, IR unchanged.
- DW=32, CARRY_FLAG_EN defined: MOV R0,#0xFF (=0xFFFFFFFF) then ADD R1,R0,R0 -> R1=0xFFFFFFFE, C=1. Then CMP R0,R0 -> Z=1, C=1.
